// File: rtl/snn_pkg.sv
// Purpose : shared field slices, count-beat layout and FSM encodings for the spike channel counter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package snn_pkg;

  // Input spike event layout: {channel, position}
  localparam int SPIKE_CH_HI  = 31;
  localparam int SPIKE_CH_LO  = 16;
  localparam int SPIKE_POS_HI = 15;
  localparam int SPIKE_POS_LO = 0;

  // Output count beat: {channel index, zero-extended count}
  localparam int CNT_BEAT_W = 32;

  typedef struct packed {
    logic [15:0] ch;
    logic [15:0] cnt;
  } count_beat_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/snn_argmax_tracker.sv
// Purpose : running argmax over a sequential (index, value) stream; strict-greater so ties keep the lowest index.
// Latency : winner_idx_o / winner_vld_o register one cycle after the beat carrying last_i.
// Backpressure: none; only consumes beats qualified by valid_i.
//
// Ports: start_i marks the first beat (running max restarts at value 0 / index 0),
//        valid_i qualifies idx_i/val_i, last_i closes the stream,
//        winner_idx_o holds the result, winner_vld_o pulses for one cycle when it updates.
module snn_argmax_tracker #(
  parameter int IDX_W = 3,
  parameter int VAL_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [VAL_W-1:0] val_i,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             winner_vld_o
);

  logic [VAL_W-1:0] max_val_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] winner_idx_q;
  logic             winner_vld_q;

  logic [VAL_W-1:0] base_val;
  logic [IDX_W-1:0] base_idx;
  logic [VAL_W-1:0] cand_val;
  logic [IDX_W-1:0] cand_idx;

  // On the first beat compare against the (0, 0) seed rather than the stale max.
  always_comb begin
    base_val = start_i ? '0 : max_val_q;
    base_idx = start_i ? '0 : max_idx_q;
    cand_val = base_val;
    cand_idx = base_idx;
    if (val_i > base_val) begin
      cand_val = val_i;
      cand_idx = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_val_q    <= '0;
      max_idx_q    <= '0;
      winner_idx_q <= '0;
      winner_vld_q <= 1'b0;
    end else begin
      winner_vld_q <= 1'b0;
      if (valid_i) begin
        max_val_q <= cand_val;
        max_idx_q <= cand_idx;
        if (last_i) begin
          winner_idx_q <= cand_idx;
          winner_vld_q <= 1'b1;
        end
      end
    end
  end

  assign winner_idx_o = winner_idx_q;
  assign winner_vld_o = winner_vld_q;

endmodule

// File: rtl/snn_spike_channel_counter.sv
// Purpose : per-channel saturating spike counts over a frame, drained as an AXI-Stream burst with argmax winner.
// Latency : first count beat valid 1 cycle after the input tlast beat; winner/frame_count 1 cycle after last count beat.
// Backpressure: input stalled (tready=0) for the whole drain; drain beats hold while m_axis tready is low.
//
// Ports: s_axis_spike_* spike events {channel, position}; m_axis_count_* count burst {channel, count};
//        winner_channel/winner_valid argmax result and update pulse; frame_count completed drains;
//        dropped_count accepted spikes on out-of-range channels; busy high while draining.
module snn_spike_channel_counter
  import snn_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int COUNT_WIDTH  = 16,
  parameter int CH_IDX_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             s_axis_spike_tdata,
  input  logic                    s_axis_spike_tvalid,
  output logic                    s_axis_spike_tready,
  input  logic                    s_axis_spike_tlast,
  output logic [CNT_BEAT_W-1:0]   m_axis_count_tdata,
  output logic                    m_axis_count_tvalid,
  input  logic                    m_axis_count_tready,
  output logic                    m_axis_count_tlast,
  output logic [CH_IDX_WIDTH-1:0] winner_channel,
  output logic                    winner_valid,
  output logic [31:0]             frame_count,
  output logic [31:0]             dropped_count,
  output logic                    busy
);

  localparam logic [15:0]             NUM_CH_W = 16'(NUM_CHANNELS);
  localparam logic [CH_IDX_WIDTH-1:0] LAST_IDX = CH_IDX_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [COUNT_WIDTH-1:0]  CNT_MAX  = '1;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  cnt_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  cnt_d [NUM_CHANNELS];
  logic [CH_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]             frame_q, frame_d;
  logic [31:0]             drop_q, drop_d;

  logic [15:0]             spike_ch;
  logic [CH_IDX_WIDTH-1:0] spike_idx;
  logic                    in_accum;
  logic                    in_drain;
  logic                    spike_acc;
  logic                    ch_ok;
  logic                    beat_acc;
  logic                    beat_last;
  logic [COUNT_WIDTH-1:0]  cur_cnt;
  count_beat_t             beat;

  // Position field carries no information for counting.
  wire unused_pos = ^s_axis_spike_tdata[SPIKE_POS_HI:SPIKE_POS_LO];

  assign spike_ch  = s_axis_spike_tdata[SPIKE_CH_HI:SPIKE_CH_LO];
  assign spike_idx = spike_ch[CH_IDX_WIDTH-1:0];
  assign in_accum  = (state_q == ST_ACCUM);
  assign in_drain  = (state_q == ST_DRAIN);
  assign spike_acc = in_accum && enable && s_axis_spike_tvalid;
  assign ch_ok     = (spike_ch < NUM_CH_W);
  assign beat_acc  = in_drain && m_axis_count_tready;
  assign beat_last = (idx_q == LAST_IDX);
  assign cur_cnt   = cnt_q[idx_q];

  // Drain outputs come straight from idx_q / cnt_q, which only move on an
  // accepted beat, so data and last stay stable while stalled.
  always_comb begin
    beat.ch  = in_drain ? 16'(idx_q) : 16'd0;
    beat.cnt = in_drain ? 16'(cur_cnt) : 16'd0;
  end

  assign m_axis_count_tdata  = beat;
  assign m_axis_count_tvalid = in_drain;
  assign m_axis_count_tlast  = in_drain && beat_last;
  assign s_axis_spike_tready = in_accum && enable;
  assign busy                = in_drain;
  assign frame_count         = frame_q;
  assign dropped_count       = drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    drop_d  = drop_q;

    if (spike_acc) begin
      if (ch_ok) begin
        if (cnt_q[spike_idx] != CNT_MAX) begin
          cnt_d[spike_idx] = cnt_q[spike_idx] + COUNT_WIDTH'(1);
        end
      end else begin
        drop_d = drop_q + 32'd1;
      end
      if (s_axis_spike_tlast) begin
        state_d = ST_DRAIN;
        idx_d   = '0;
      end
    end

    // Each drained channel is cleared so the next frame starts from zero.
    if (beat_acc) begin
      cnt_d[idx_q] = '0;
      if (beat_last) begin
        state_d = ST_ACCUM;
        idx_d   = '0;
        frame_d = frame_q + 32'd1;
      end else begin
        idx_d = idx_q + CH_IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      frame_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  snn_argmax_tracker #(
    .IDX_W (CH_IDX_WIDTH),
    .VAL_W (COUNT_WIDTH)
  ) u_argmax (
    .clk          (clk),
    .reset        (reset),
    .start_i      (idx_q == '0),
    .valid_i      (beat_acc),
    .last_i       (beat_last),
    .idx_i        (idx_q),
    .val_i        (cur_cnt),
    .winner_idx_o (winner_channel),
    .winner_vld_o (winner_valid)
  );

endmodule

// File: tb/tb_snn_spike_channel_counter.sv
// Purpose : directed self-checking bench for snn_spike_channel_counter.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: exercises steady and toggling m_axis tready.
module tb_snn_spike_channel_counter;

  localparam int NCH = 8;
  localparam int CW  = 16;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [31:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [IW-1:0] winner_channel;
  logic          winner_valid;
  logic [31:0]   frame_count;
  logic [31:0]   dropped_count;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt [NCH];

  always #5 clk = ~clk;

  snn_spike_channel_counter #(
    .NUM_CHANNELS (NCH),
    .COUNT_WIDTH  (CW),
    .CH_IDX_WIDTH (IW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .s_axis_spike_tdata  (s_tdata),
    .s_axis_spike_tvalid (s_tvalid),
    .s_axis_spike_tready (s_tready),
    .s_axis_spike_tlast  (s_tlast),
    .m_axis_count_tdata  (m_tdata),
    .m_axis_count_tvalid (m_tvalid),
    .m_axis_count_tready (m_tready),
    .m_axis_count_tlast  (m_tlast),
    .winner_channel      (winner_channel),
    .winner_valid        (winner_valid),
    .frame_count         (frame_count),
    .dropped_count       (dropped_count),
    .busy                (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NCH; i++) exp_cnt[i] = 16'd0;
  endtask

  // n spikes to one channel, back to back; tlast optionally on the final one.
  // Returns at the falling edge after the final beat was accepted.
  task automatic send(input logic [15:0] ch, input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) begin
      bit acc;
      s_tdata  = {ch, 16'(i)};
      s_tlast  = last_on_final && (i == n - 1);
      s_tvalid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        if (s_tready) acc = 1'b1;
        @(negedge clk);
      end
      if (!acc) chk("spike_accept_timeout", 32'd0, 32'd1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Collects the whole burst against exp_cnt, then checks winner/pulse/idle.
  task automatic drain(input bit toggle, input logic [IW-1:0] exp_win, input logic [31:0] exp_frames);
    int          k;
    bit          stalled;
    bit          done;
    logic [31:0] held;
    logic        held_last;
    k = 0; stalled = 1'b0; done = 1'b0; held = '0; held_last = 1'b0;
    chk("first_beat_latency", 32'(m_tvalid), 32'd1);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      chk("in_tready_in_drain", 32'(s_tready), 32'd0);
      chk("busy_in_drain", 32'(busy), 32'd1);
      if (stalled) begin
        chk("stall_hold_data", m_tdata, held);
        chk("stall_hold_last", 32'(m_tlast), 32'(held_last));
      end
      m_tready = toggle ? (cyc[0] == 1'b0) : 1'b1;
      if (m_tvalid) begin
        if (m_tready) begin
          chk($sformatf("beat%0d_data", k), m_tdata, {k[15:0], exp_cnt[k]});
          chk($sformatf("beat%0d_last", k), 32'(m_tlast), 32'(k == NCH - 1));
          k++;
          stalled = 1'b0;
          if (k == NCH) done = 1'b1;
        end else begin
          held      = m_tdata;
          held_last = m_tlast;
          stalled   = 1'b1;
        end
      end
      @(negedge clk);
    end
    m_tready = 1'b0;
    if (!done) chk("drain_timeout_beats", 32'(k), 32'(NCH));
    chk("winner_valid_pulse", 32'(winner_valid), 32'd1);
    chk("winner_channel", 32'(winner_channel), 32'(exp_win));
    chk("busy_after_drain", 32'(busy), 32'd0);
    chk("tvalid_after_drain", 32'(m_tvalid), 32'd0);
    chk("in_tready_after_drain", 32'(s_tready), 32'd1);
    chk("frame_count", frame_count, exp_frames);
    @(negedge clk);
    chk("winner_valid_one_cycle", 32'(winner_valid), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", frame_count, 32'd0);
    chk("rst_dropped", dropped_count, 32'd0);
    chk("rst_winner", 32'(winner_channel), 32'd0);
    chk("rst_winner_valid", 32'(winner_valid), 32'd0);
    chk("disabled_tready", 32'(s_tready), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("enabled_tready", 32'(s_tready), 32'd1);

    // Basic frame, tready high
    send(16'd2, 3, 1'b0);
    send(16'd5, 1, 1'b1);
    clear_exp(); exp_cnt[2] = 16'd3; exp_cnt[5] = 16'd1;
    drain(1'b0, 3'd2, 32'd1);

    // Same frame, downstream ready toggling
    send(16'd2, 3, 1'b0);
    send(16'd5, 1, 1'b1);
    drain(1'b1, 3'd2, 32'd2);

    // Saturation, then fresh frame starts from zero
    send(16'd0, 65540, 1'b1);
    clear_exp(); exp_cnt[0] = 16'hFFFF;
    drain(1'b0, 3'd0, 32'd3);
    send(16'd0, 2, 1'b1);
    clear_exp(); exp_cnt[0] = 16'd2;
    drain(1'b0, 3'd0, 32'd4);

    // Out-of-range channels are dropped
    send(16'd9, 1, 1'b0);
    send(16'd100, 1, 1'b0);
    send(16'd1, 1, 1'b1);
    chk("dropped_two", dropped_count, 32'd2);
    clear_exp(); exp_cnt[1] = 16'd1;
    drain(1'b0, 3'd1, 32'd5);

    // Tie goes to the lowest index
    send(16'd3, 4, 1'b0);
    send(16'd6, 3, 1'b0);
    send(16'd6, 1, 1'b1);
    clear_exp(); exp_cnt[3] = 16'd4; exp_cnt[6] = 16'd4;
    drain(1'b1, 3'd3, 32'd6);

    // Frame with only an invalid-channel tlast spike
    send(16'd8, 1, 1'b1);
    chk("dropped_three", dropped_count, 32'd3);
    clear_exp();
    drain(1'b0, 3'd0, 32'd7);

    // Reset three beats into a drain
    send(16'd5, 2, 1'b1);
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    m_tready = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tdata", m_tdata, 32'd0);
    chk("midrst_frames", frame_count, 32'd0);
    chk("midrst_dropped", dropped_count, 32'd0);
    chk("midrst_winner", 32'(winner_channel), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    send(16'd4, 2, 1'b1);
    clear_exp(); exp_cnt[4] = 16'd2;
    drain(1'b0, 3'd4, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
